// File: rtl/sfft_snapshot_pkg.sv
// rtl/sfft_snapshot_pkg.sv - shared offsets, status layout and helpers for the SFFT snapshot buffer.
package sfft_snapshot_pkg;

   localparam int CNT_OFS  = 0;
   localparam int STAT_OFS = 4;
   localparam int CTRL_OFS = 4;
   localparam int BIN_OFS  = 8;
   localparam int SAT_W    = 8;
   localparam int TEST_NWORDS = 8;

   localparam logic [31:0] TEST_WORDS [TEST_NWORDS] = '{
      32'h11223344, 32'h00000000, 32'hFFFFFFFF, 32'hFF000000,
      32'hFF00FF00, 32'hF0000000, 32'hD2000000, 32'h01234567
   };

   typedef struct packed {
      logic [4:0] rsvd;
      logic       pending;
      logic       lock;
      logic       frame_ready;
   } status_t;

   function automatic logic [SAT_W-1:0] sat_inc(input logic [SAT_W-1:0] v);
      return (v == '1) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/sfft_snapshot_bank.sv
// rtl/sfft_snapshot_bank.sv - ping-pong bin RAM: writes land in the back bank, reads come from the front.
module sfft_snapshot_bank #(
   parameter int NBINS = 128,
   parameter int IDX_W = 7
) (
   input  logic             clk,
   input  logic             front,
   input  logic             wr_en,
   input  logic [IDX_W-1:0] wr_idx,
   input  logic [31:0]      wr_data,
   input  logic             rd_en,
   input  logic [IDX_W-1:0] rd_idx,
   output logic [31:0]      rd_data
);

   logic [31:0] mem [2][NBINS];

   always_ff @(posedge clk) begin
      if (wr_en) mem[~front][wr_idx] <= wr_data;
      if (rd_en) rd_data <= mem[front][rd_idx];
   end

endmodule

// File: rtl/sfft_snapshot_buffer.sv
// rtl/sfft_snapshot_buffer.sv - double-buffered SFFT frame snapshot with byte-wide driver port.
// Optional test-pattern words after the bins: SFFT_SNAPSHOT_TEST_PATTERN_EN.
module sfft_snapshot_buffer
   import sfft_snapshot_pkg::*;
#(
   parameter int NBINS  = 128,
   parameter int BIN_W  = 32,
   parameter int TIME_W = 32,
   parameter int ADDR_W = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              bin_valid,
   input  logic [BIN_W-1:0]  bin_data,
   input  logic              bin_last,
   input  logic              chipselect,
   input  logic              read,
   input  logic              write,
   input  logic [ADDR_W-1:0] address,
   input  logic [7:0]        writedata,
   output logic [7:0]        readdata,
   output logic              frame_ready,
   output logic              frame_pulse
);

   localparam int IDX_W = $clog2(NBINS);
   localparam int CNT_W = $clog2(NBINS + 1);
   localparam logic [31:0] A_BIN  = 32'(BIN_OFS);
   localparam logic [31:0] A_TEST = 32'(BIN_OFS + 4 * NBINS);

   logic [CNT_W-1:0]  idx;
   logic              front, lock, pending, published_once;
   logic [TIME_W-1:0] frame_cnt;
   logic [SAT_W-1:0]  ovr_cnt, err_cnt;
   logic [31:0]       ram_q;
   logic              bin_sel_q;
   logic [1:0]        lane_q;
   logic [7:0]        reg_q;

   logic discarding, at_last, bin_wr, good_done, frame_err, overrun;
   logic ctrl_wr, lock_eff, publish, rd_en, in_bins;
   logic [31:0] a, cnt32;
   logic [IDX_W-1:0] rd_idx;
   logic [7:0] reg_byte;
   status_t status;
   logic unused_wdata;

   assign unused_wdata = ^writedata[7:1];

   always_comb begin
      discarding = (idx == CNT_W'(NBINS));
      at_last    = (idx == CNT_W'(NBINS - 1));
      bin_wr     = bin_valid && !discarding;
      good_done  = bin_wr && bin_last && at_last;
      // short frame (early bin_last) or long frame (NBINS reached) - each counted once
      frame_err  = bin_wr && (bin_last != at_last);
      overrun    = bin_wr && (idx == '0) && pending && lock;
      ctrl_wr    = chipselect && write && (address == ADDR_W'(CTRL_OFS));
      lock_eff   = ctrl_wr ? writedata[0] : lock;
      publish    = (good_done && !lock_eff) || (pending && !lock);
      rd_en      = chipselect && read;
   end

   always_comb begin
      a        = 32'(address);
      cnt32    = 32'(frame_cnt);
      in_bins  = (a >= A_BIN) && (a < A_TEST);
      rd_idx   = IDX_W'((a - A_BIN) >> 2);
      status   = '{rsvd: 5'd0, pending: pending, lock: lock, frame_ready: frame_ready};
      reg_byte = 8'h00;
      if (a < 32'(STAT_OFS))
         reg_byte = cnt32[{a[1:0], 3'b000} +: 8];
      else if (a == 32'(STAT_OFS))
         reg_byte = status;
      else if (a == 32'(STAT_OFS + 1))
         reg_byte = ovr_cnt;
      else if (a == 32'(STAT_OFS + 2))
         reg_byte = err_cnt;
`ifdef SFFT_SNAPSHOT_TEST_PATTERN_EN
      else if ((a >= A_TEST) && (a < A_TEST + 32'd32))
         reg_byte = TEST_WORDS[3'((a - A_TEST) >> 2)][{a[1:0], 3'b000} +: 8];
`endif
   end

   sfft_snapshot_bank #(.NBINS(NBINS), .IDX_W(IDX_W)) u_bank (
      .clk     (clk),
      .front   (front),
      .wr_en   (bin_wr),
      .wr_idx  (idx[IDX_W-1:0]),
      .wr_data (32'(bin_data)),
      .rd_en   (rd_en && in_bins),
      .rd_idx  (rd_idx),
      .rd_data (ram_q)
   );

   // RAM output and captured register byte both hold between reads, so readdata holds too
   assign readdata = bin_sel_q ? ram_q[{lane_q, 3'b000} +: 8] : reg_q;

   always_ff @(posedge clk) begin
      if (!reset) begin
         idx            <= '0;
         front          <= 1'b0;
         lock           <= 1'b0;
         pending        <= 1'b0;
         published_once <= 1'b0;
         frame_cnt      <= '0;
         ovr_cnt        <= '0;
         err_cnt        <= '0;
         frame_ready    <= 1'b0;
         frame_pulse    <= 1'b0;
         bin_sel_q      <= 1'b0;
         lane_q         <= 2'd0;
         reg_q          <= 8'h00;
      end else begin
         frame_pulse <= publish;
         if (bin_valid)
            idx <= bin_last ? '0 : (discarding ? idx : idx + 1'b1);
         if (frame_err) err_cnt <= sat_inc(err_cnt);
         if (overrun)   ovr_cnt <= sat_inc(ovr_cnt);
         if (ctrl_wr)   lock <= writedata[0];
         if (good_done && lock_eff)
            pending <= 1'b1;
         else if (publish || overrun)
            pending <= 1'b0;
         if (publish) begin
            front          <= ~front;
            frame_cnt      <= frame_cnt + 1'b1;
            published_once <= 1'b1;
         end
         if (publish)
            frame_ready <= 1'b1;
         else if (rd_en && (address == ADDR_W'(CNT_OFS)))
            frame_ready <= 1'b0;
         if (rd_en) begin
            bin_sel_q <= in_bins && published_once;
            lane_q    <= a[1:0];
            reg_q     <= reg_byte;
         end
      end
   end

endmodule

// File: tb/tb_sfft_snapshot_buffer.sv
// tb/tb_sfft_snapshot_buffer.sv - scoreboard bench for sfft_snapshot_buffer (small TIME_W to reach wrap).
module tb_sfft_snapshot_buffer;

   localparam int NBINS    = 128;
   localparam int BIN_W    = 32;
   localparam int TIME_W   = 4;
   localparam int ADDR_W   = 16;
   localparam int TEST_OFS = 8 + 4 * NBINS;

   logic clk = 1'b0, reset = 1'b0;
   logic bin_valid = 1'b0, bin_last = 1'b0;
   logic chipselect = 1'b0, read = 1'b0, write = 1'b0;
   logic [BIN_W-1:0]  bin_data = '0;
   logic [ADDR_W-1:0] address = '0;
   logic [7:0]        writedata = '0;
   logic [7:0]        readdata;
   logic              frame_ready, frame_pulse;

   int checks = 0, failures = 0, pulses = 0;
   logic [7:0] exp_q[$];
   string      name_q[$];
   logic       rd_q = 1'b0;
   logic [7:0] mon_e;
   string      mon_n;

   always #5 clk = ~clk;

   sfft_snapshot_buffer #(.NBINS(NBINS), .BIN_W(BIN_W), .TIME_W(TIME_W), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .reset(reset), .bin_valid(bin_valid), .bin_data(bin_data), .bin_last(bin_last),
      .chipselect(chipselect), .read(read), .write(write), .address(address), .writedata(writedata),
      .readdata(readdata), .frame_ready(frame_ready), .frame_pulse(frame_pulse)
   );

   always @(posedge clk) rd_q <= chipselect & read;

   always @(negedge clk) begin
      if (frame_pulse) pulses++;
      if (rd_q) begin
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL rd_unexpected got=%02h required=none", readdata);
         end else begin
            mon_e = exp_q.pop_front();
            mon_n = name_q.pop_front();
            if (readdata !== mon_e) begin
               failures++;
               $display("FAIL %s got=%02h required=%02h", mon_n, readdata, mon_e);
            end
         end
      end
   end

   initial begin
      #2ms;
      $display("FAIL watchdog got=timeout required=finish");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(string nm, logic [31:0] got, logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h required=%0h", nm, got, exp);
      end
   endtask

   task automatic rd(int addr, logic [7:0] e, string nm);
      chipselect = 1'b1; read = 1'b1; address = ADDR_W'(addr);
      exp_q.push_back(e);
      name_q.push_back(nm);
      tick();
      chipselect = 1'b0; read = 1'b0;
   endtask

   task automatic rd_word(int addr, logic [31:0] e, string nm);
      for (int k = 0; k < 4; k++) rd(addr + k, e[8*k +: 8], nm);
   endtask

   task automatic wr(int addr, logic [7:0] d);
      chipselect = 1'b1; write = 1'b1; address = ADDR_W'(addr); writedata = d;
      tick();
      chipselect = 1'b0; write = 1'b0;
   endtask

   task automatic send_frame(int n, logic [31:0] base, int last_at);
      for (int i = 0; i < n; i++) begin
         bin_valid = 1'b1;
         bin_data  = base + 32'(i);
         bin_last  = (i == last_at - 1);
         tick();
      end
      bin_valid = 1'b0; bin_last = 1'b0;
      tick();
   endtask

   initial begin
      repeat (3) tick();
      check("rst_frame_ready", 32'(frame_ready), 0);
      check("rst_frame_pulse", 32'(frame_pulse), 0);
      check("rst_readdata", 32'(readdata), 0);
      reset = 1'b1;
      tick();

      rd(8, 8'h00, "bin_unpublished");
      rd(4, 8'h00, "status_reset");
`ifdef SFFT_SNAPSHOT_TEST_PATTERN_EN
      rd(TEST_OFS + 28, 8'h67, "test_word7_b0");
      rd(TEST_OFS, 8'h44, "test_word0_b0");
`else
      rd(TEST_OFS + 28, 8'h00, "test_region_off");
      rd(TEST_OFS, 8'h00, "test_region_off0");
`endif
      rd(TEST_OFS + 32, 8'h00, "past_test_region");

      send_frame(NBINS, 32'd1, NBINS);
      check("pulse_first", 32'(pulses), 1);
      check("ready_first", 32'(frame_ready), 1);
      rd(4, 8'h01, "status_ready");
      rd_word(0, 32'd1, "cnt_first");
      check("ready_cleared", 32'(frame_ready), 0);
      rd_word(8, 32'd1, "bin0_first");
      rd_word(8 + 4 * (NBINS - 1), 32'(NBINS), "binlast_first");

      wr(4, 8'h01);
      rd(4, 8'h02, "status_locked");
      send_frame(NBINS, 32'h100, NBINS);
      send_frame(NBINS, 32'h200, NBINS);
      rd(5, 8'h01, "overrun_cnt");
      rd(4, 8'h06, "status_pending");
      rd_word(0, 32'd1, "cnt_locked");
      rd_word(8, 32'd1, "bin0_locked");
      check("no_pulse_locked", 32'(pulses), 1);
      wr(4, 8'h00);
      check("unlock_pulse_early", 32'(frame_pulse), 0);
      tick();
      check("unlock_pulse", 32'(frame_pulse), 1);
      rd(4, 8'h01, "status_unlocked");
      rd_word(0, 32'd2, "cnt_unlock");
      rd_word(8, 32'h200, "bin0_second");
      rd_word(8 + 4 * (NBINS - 1), 32'h27F, "binlast_second");

      send_frame(50, 32'h300, 50);
      send_frame(NBINS + 2, 32'h400, NBINS + 2);
      rd(6, 8'h02, "err_cnt");
      rd_word(0, 32'd2, "cnt_after_err");
      rd_word(8, 32'h200, "bin0_after_err");
      check("pulse_after_err", 32'(pulses), 2);
      wr(0, 8'hFF);
      tick();
      rd_word(0, 32'd2, "cnt_write_ignored");

      for (int i = 0; i < 60; i++) begin
         bin_valid = 1'b1; bin_data = 32'h500 + 32'(i); bin_last = 1'b0;
         tick();
      end
      bin_valid = 1'b0;
      reset = 1'b0;
      tick(); tick();
      reset = 1'b1;
      tick();
      check("ready_after_reset", 32'(frame_ready), 0);
      rd(8, 8'h00, "bin_after_reset");
      rd(5, 8'h00, "ovr_after_reset");
      rd(6, 8'h00, "err_after_reset");
      rd(4, 8'h00, "status_after_reset");
      rd_word(0, 32'd0, "cnt_after_reset");
      send_frame(NBINS, 32'h600, NBINS);
      rd_word(0, 32'd1, "cnt_reset_frame");
      for (int i = 0; i < NBINS; i++) rd_word(8 + 4 * i, 32'h600 + 32'(i), "bin_reset_frame");

      for (int k = 0; k < 15; k++) send_frame(NBINS, 32'h1000 * 32'(k + 1), NBINS);
      rd_word(0, 32'd0, "cnt_wrap");
      rd_word(8, 32'hF000, "bin0_wrap");
      check("pulse_total", 32'(pulses), 18);

      for (int i = 0; i < 300; i++) begin
         bin_valid = 1'b1; bin_last = 1'b1; bin_data = '0;
         tick();
      end
      bin_valid = 1'b0; bin_last = 1'b0;
      tick();
      rd(6, 8'hFF, "err_saturated");
      rd_word(0, 32'd0, "cnt_after_sat");
      check("pulse_after_sat", 32'(pulses), 18);

      tick(); tick();
      check("scoreboard_drained", 32'(exp_q.size()), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
